squash_game_sequencer: RTL and testbench

Frame-rate game sequencer for the solo squash design. It sits between the board control inputs and the ball/paddle datapath. It conditions the pause and new-game buttons, runs the serve/play/miss/game-over state machine, keeps score and lives, and schedules the speaker's tone requests from datapath collision events. It never touches VGA timing. It only gates the datapath through `run_en` and `serve`.

---
 rtl/squash_pkg.sv | 35 +++
 rtl/squash_button_conditioner.sv | 76 +++++++
 rtl/squash_game_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_squash_game_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/squash_pkg.sv
// Shared types and constants for the squash game sequencer.
// Contents: FSM state enum, tone codes, tone durations (in frame ticks) and
// a helper that ranks tone codes by priority (miss > paddle > wall > none).
package squash_pkg;

  typedef enum logic [2:0] {
    StAttract,
    StServe,
    StPlay,
    StMiss,
    StPause,
    StOver
  } state_e;

  localparam logic [1:0] TONE_NONE   = 2'd0;
  localparam logic [1:0] TONE_PADDLE = 2'd1;
  localparam logic [1:0] TONE_WALL   = 2'd2;
  localparam logic [1:0] TONE_MISS   = 2'd3;

  localparam int unsigned TONE_DUR_MISS   = 16;
  localparam int unsigned TONE_DUR_PADDLE = 4;
  localparam int unsigned TONE_DUR_WALL   = 2;
  localparam int unsigned ToneCntW        = 5;

  // Tone codes are not ordered by priority, so rank them explicitly.
  function automatic logic [1:0] tone_prio(input logic [1:0] sel);
    case (sel)
      TONE_MISS:   return 2'd3;
      TONE_PADDLE: return 2'd2;
      TONE_WALL:   return 2'd1;
      default:     return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/squash_button_conditioner.sv
// Button conditioner: 2-flop synchronizer, optional frame-tick debounce and
// press-edge detector for one active-low push button.
// Ports:
//   clk_i        clock
//   reset_i      synchronous active-high reset (synchronizer resets to released)
//   frame_tick_i one-cycle pulse per frame (used only by the debouncer)
//   btn_ni       raw active-low button level, asynchronous
//   press_o      one-cycle pulse on the released->pressed transition
// Build option: define SQUASH_DEBOUNCE_EN to require the synchronized level
// to be stable for 3 consecutive frame ticks before it is accepted.
module squash_button_conditioner (
  input  logic clk_i,
  input  logic reset_i,
  input  logic frame_tick_i,
  input  logic btn_ni,
  output logic press_o
);

  logic sync1_q, sync2_q, prev_q;
  logic raw, cond;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_ni;
      sync2_q <= sync1_q;
      prev_q  <= cond;
    end
  end

  assign raw = ~sync2_q;

`ifdef SQUASH_DEBOUNCE_EN
  logic       deb_q, deb_d;
  logic [1:0] stab_q, stab_d;

  // Count ticks while the raw level disagrees with the accepted level; any
  // return to agreement restarts the count.
  always_comb begin
    deb_d  = deb_q;
    stab_d = stab_q;
    if (raw == deb_q) begin
      stab_d = '0;
    end else if (frame_tick_i) begin
      if (stab_q == 2'd2) begin
        deb_d  = raw;
        stab_d = '0;
      end else begin
        stab_d = stab_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      deb_q  <= 1'b0;
      stab_q <= '0;
    end else begin
      deb_q  <= deb_d;
      stab_q <= stab_d;
    end
  end

  assign cond = deb_q;
`else
  logic unused_tick;
  assign unused_tick = frame_tick_i;
  assign cond        = raw;
`endif

  assign press_o = cond & ~prev_q;

endmodule

// File: rtl/squash_game_sequencer.sv
// Frame-rate game sequencer for the solo squash design: conditions the pause
// and new-game buttons, runs the attract/serve/play/miss/pause/over FSM, keeps
// score and lives, and schedules speaker tones from collision events.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   frame_tick               one-cycle pulse per frame
//   pause_n, new_game_n      active-low asynchronous buttons
//   hit_paddle, hit_wall,
//   ball_missed              one-cycle collision pulses from the datapath
//   run_en, serve            datapath gating (motion enable, ball reload pulse)
//   score, lives             game counters
//   paused, game_over        status flags
//   tone_en, tone_sel        speaker gate and tone code
// Build option: SQUASH_DEBOUNCE_EN enables button debounce in the conditioners.
module squash_game_sequencer
  import squash_pkg::*;
#(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned MISS_FRAMES  = 30,
  parameter int unsigned SCORE_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               pause_n,
  input  logic               new_game_n,
  input  logic               hit_paddle,
  input  logic               hit_wall,
  input  logic               ball_missed,
  output logic               run_en,
  output logic               serve,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic               paused,
  output logic               game_over,
  output logic               tone_en,
  output logic [1:0]         tone_sel
);

  localparam int unsigned CntMax = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] ServeLoad = CntW'(SERVE_FRAMES);
  localparam logic [CntW-1:0] MissLoad  = CntW'(MISS_FRAMES);

  logic pause_press, new_game_press;

  squash_button_conditioner u_pause_btn (
    .clk_i        (clk),
    .reset_i      (reset),
    .frame_tick_i (frame_tick),
    .btn_ni       (pause_n),
    .press_o      (pause_press)
  );

  squash_button_conditioner u_new_game_btn (
    .clk_i        (clk),
    .reset_i      (reset),
    .frame_tick_i (frame_tick),
    .btn_ni       (new_game_n),
    .press_o      (new_game_press)
  );

  state_e                state_q, state_d, ret_q, ret_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [SCORE_W-1:0]    score_q, score_d;
  logic [2:0]            lives_q, lives_d;
  logic                  serve_q, serve_d, run_en_q, run_en_d;
  logic                  paused_q, paused_d, over_q, over_d;
  logic                  tone_en_q, tone_en_d;
  logic [1:0]            tone_sel_q, tone_sel_d, ev_sel;
  logic [ToneCntW-1:0]   tone_cnt_q, tone_cnt_d, ev_dur;
  logic                  miss_evt, paddle_evt, wall_evt, expire;

  // The counter is treated as expired at 1 (or 0) so a degenerate load of 0
  // cannot underflow and stall the state.
  assign expire = frame_tick && (cnt_q <= CntW'(1));

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    cnt_d      = cnt_q;
    score_d    = score_q;
    lives_d    = lives_q;
    serve_d    = 1'b0;
    miss_evt   = 1'b0;
    paddle_evt = 1'b0;
    wall_evt   = 1'b0;
    if (new_game_press) begin
      state_d = StServe;
      score_d = '0;
      lives_d = 3'(LIVES);
      cnt_d   = ServeLoad;
      serve_d = 1'b1;
    end else if (pause_press && (state_q == StServe || state_q == StPlay)) begin
      state_d = StPause;
      ret_d   = state_q;
    end else if (pause_press && state_q == StPause) begin
      state_d = ret_q;
    end else begin
      case (state_q)
        StServe: begin
          if (expire) begin
            state_d = StPlay;
            cnt_d   = '0;
          end else if (frame_tick) begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StPlay: begin
          if (ball_missed) begin
            miss_evt = 1'b1;
            state_d  = StMiss;
            cnt_d    = MissLoad;
            if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
          end else begin
            paddle_evt = hit_paddle;
            wall_evt   = hit_wall;
            if (hit_paddle && score_q != {SCORE_W{1'b1}}) score_d = score_q + SCORE_W'(1);
          end
        end
        StMiss: begin
          if (expire) begin
            if (lives_q == 3'd0) begin
              state_d = StOver;
              cnt_d   = '0;
            end else begin
              state_d = StServe;
              cnt_d   = ServeLoad;
              serve_d = 1'b1;
            end
          end else if (frame_tick) begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Tone scheduler: equal-or-higher priority events retrigger, lower ones drop.
  always_comb begin
    ev_sel     = TONE_NONE;
    ev_dur     = '0;
    tone_sel_d = tone_sel_q;
    tone_cnt_d = tone_cnt_q;
    if (miss_evt) begin
      ev_sel = TONE_MISS;
      ev_dur = ToneCntW'(TONE_DUR_MISS);
    end else if (paddle_evt) begin
      ev_sel = TONE_PADDLE;
      ev_dur = ToneCntW'(TONE_DUR_PADDLE);
    end else if (wall_evt) begin
      ev_sel = TONE_WALL;
      ev_dur = ToneCntW'(TONE_DUR_WALL);
    end
    if (state_d == StPause || state_d == StOver) begin
      tone_sel_d = TONE_NONE;
      tone_cnt_d = '0;
    end else if (ev_sel != TONE_NONE && tone_prio(ev_sel) >= tone_prio(tone_sel_q)) begin
      tone_sel_d = ev_sel;
      tone_cnt_d = ev_dur;
    end else if (frame_tick && tone_cnt_q != '0) begin
      tone_cnt_d = tone_cnt_q - ToneCntW'(1);
      if (tone_cnt_q == ToneCntW'(1)) tone_sel_d = TONE_NONE;
    end
    tone_en_d = (tone_sel_d != TONE_NONE);
  end

  assign run_en_d = (state_d == StPlay);
  assign paused_d = (state_d == StPause);
  assign over_d   = (state_d == StOver) || (state_d == StAttract);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StAttract;
      ret_q      <= StAttract;
      cnt_q      <= '0;
      score_q    <= '0;
      lives_q    <= '0;
      serve_q    <= 1'b0;
      run_en_q   <= 1'b0;
      paused_q   <= 1'b0;
      over_q     <= 1'b1;
      tone_en_q  <= 1'b0;
      tone_sel_q <= TONE_NONE;
      tone_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      cnt_q      <= cnt_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      serve_q    <= serve_d;
      run_en_q   <= run_en_d;
      paused_q   <= paused_d;
      over_q     <= over_d;
      tone_en_q  <= tone_en_d;
      tone_sel_q <= tone_sel_d;
      tone_cnt_q <= tone_cnt_d;
    end
  end

  assign run_en    = run_en_q;
  assign serve     = serve_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign paused    = paused_q;
  assign game_over = over_q;
  assign tone_en   = tone_en_q;
  assign tone_sel  = tone_sel_q;

endmodule

// File: tb/tb_squash_game_sequencer.sv
// Self-checking bench for squash_game_sequencer: scenario tasks with random
// gaps, tick spacing and event mixes, checked against expectations computed
// from the game rules (counts of ticks, saturating score, tone priority table).
module tb_squash_game_sequencer;

  localparam int unsigned LIVES        = 3;
  localparam int unsigned SERVE_FRAMES = 60;
  localparam int unsigned MISS_FRAMES  = 30;
  localparam int unsigned SCORE_W      = 8;
  localparam int          ScoreMax     = (1 << SCORE_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1, frame_tick = 1'b0, pause_n = 1'b1, new_game_n = 1'b1;
  logic hit_paddle = 1'b0, hit_wall = 1'b0, ball_missed = 1'b0;
  logic run_en, serve, paused, game_over, tone_en;
  logic [SCORE_W-1:0] score;
  logic [2:0] lives;
  logic [1:0] tone_sel;

  int checks = 0, errors = 0, serve_seen = 0;
  int m_score, m_lives;

  always #5 clk = ~clk;

  squash_game_sequencer #(
    .LIVES        (LIVES),
    .SERVE_FRAMES (SERVE_FRAMES),
    .MISS_FRAMES  (MISS_FRAMES),
    .SCORE_W      (SCORE_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .pause_n     (pause_n),
    .new_game_n  (new_game_n),
    .hit_paddle  (hit_paddle),
    .hit_wall    (hit_wall),
    .ball_missed (ball_missed),
    .run_en      (run_en),
    .serve       (serve),
    .score       (score),
    .lives       (lives),
    .paused      (paused),
    .game_over   (game_over),
    .tone_en     (tone_en),
    .tone_sel    (tone_sel)
  );

  initial begin
    #1_000_000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

  // Stimulus plumbing only; all checks live in the scenario tasks.
  task automatic step();
    @(posedge clk);
    #1;
    if (serve === 1'b1) serve_seen++;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      gap();
    end
  endtask

  task automatic press_pause();
    pause_n = 1'b0;
    repeat (3) step();
    pause_n = 1'b1;
    repeat (3) step();
  endtask

  task automatic press_new_game();
    new_game_n = 1'b0;
    repeat (3) step();
    new_game_n = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    hit_paddle = 1'($urandom_range(0, 1));
    hit_wall = 1'($urandom_range(0, 1));
    repeat (3) step();
    checks++; if (run_en !== 1'b0) begin errors++; $display("FAIL reset_run_en got %b want 0", run_en); end
    checks++; if (serve !== 1'b0) begin errors++; $display("FAIL reset_serve got %b want 0", serve); end
    checks++; if (score !== '0) begin errors++; $display("FAIL reset_score got %0d want 0", score); end
    checks++; if (lives !== 3'd0) begin errors++; $display("FAIL reset_lives got %0d want 0", lives); end
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL reset_paused got %b want 0", paused); end
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL reset_game_over got %b want 1", game_over); end
    checks++; if (tone_en !== 1'b0) begin errors++; $display("FAIL reset_tone_en got %b want 0", tone_en); end
    checks++; if (tone_sel !== 2'd0) begin errors++; $display("FAIL reset_tone_sel got %0d want 0", tone_sel); end
    reset = 1'b0;
    hit_paddle = 1'b0;
    hit_wall = 1'b0;
    serve_seen = 0;
    repeat (5) step();
    // Collisions in ATTRACT are ignored.
    hit_paddle = 1'b1;
    step();
    hit_paddle = 1'b0;
    step();
    checks++; if (serve_seen != 0 || game_over !== 1'b1) begin
      errors++; $display("FAIL no_spurious_press got serves=%0d over=%b want 0 1", serve_seen, game_over);
    end
    checks++; if (score !== '0 || tone_sel !== 2'd0) begin
      errors++; $display("FAIL attract_ignores_hits got score=%0d tone=%0d want 0 0", score, tone_sel);
    end
  endtask

  task automatic test_new_game();
    serve_seen = 0;
    new_game_n = 1'b0;
    repeat (2) step();
    frame_tick = 1'b1;  // coincides with SERVE entry; must not count
    step();
    frame_tick = 1'b0;
    m_score = 0;
    m_lives = LIVES;
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL ng_game_over got %b want 0", game_over); end
    checks++; if (lives !== 3'(m_lives)) begin errors++; $display("FAIL ng_lives got %0d want %0d", lives, m_lives); end
    checks++; if (score !== SCORE_W'(m_score)) begin errors++; $display("FAIL ng_score got %0d want 0", score); end
    checks++; if (serve !== 1'b1) begin errors++; $display("FAIL ng_serve got %b want 1", serve); end
    new_game_n = 1'b1;
    repeat (3) step();
    checks++; if (serve_seen != 1) begin errors++; $display("FAIL ng_serve_once got %0d want 1", serve_seen); end
    ticks(SERVE_FRAMES - 1);
    checks++; if (run_en !== 1'b0) begin errors++; $display("FAIL ng_run_early got %b want 0", run_en); end
    tick();
    checks++; if (run_en !== 1'b1) begin errors++; $display("FAIL ng_run_en got %b want 1", run_en); end
  endtask

  task automatic test_simultaneous();
    int k;
    k = $urandom_range(1, 5);
    for (int i = 0; i < k; i++) begin
      hit_paddle = 1'b1;
      step();
      hit_paddle = 1'b0;
      gap();
    end
    m_score += k;
    checks++; if (score !== SCORE_W'(m_score)) begin errors++; $display("FAIL sim_pre_score got %0d want %0d", score, m_score); end
    ball_missed = 1'b1;
    hit_paddle = 1'b1;
    step();
    ball_missed = 1'b0;
    hit_paddle = 1'b0;
    m_lives--;
    checks++; if (score !== SCORE_W'(m_score)) begin errors++; $display("FAIL sim_score got %0d want %0d", score, m_score); end
    checks++; if (lives !== 3'(m_lives)) begin errors++; $display("FAIL sim_lives got %0d want %0d", lives, m_lives); end
    checks++; if (tone_sel !== 2'd3 || tone_en !== 1'b1) begin
      errors++; $display("FAIL sim_tone got sel=%0d en=%b want 3 1", tone_sel, tone_en);
    end
    checks++; if (run_en !== 1'b0) begin errors++; $display("FAIL sim_run_en got %b want 0", run_en); end
    for (int i = 1; i <= int'(MISS_FRAMES); i++) begin
      tick();
      if (i == 15) begin
        checks++; if (tone_sel !== 2'd3) begin errors++; $display("FAIL miss_tone_hold got %0d want 3", tone_sel); end
      end
      if (i == 16) begin
        checks++; if (tone_sel !== 2'd0 || tone_en !== 1'b0) begin
          errors++; $display("FAIL miss_tone_end got sel=%0d en=%b want 0 0", tone_sel, tone_en);
        end
      end
      if (i == int'(MISS_FRAMES)) begin
        checks++; if (serve !== 1'b1) begin errors++; $display("FAIL miss_to_serve got %b want 1", serve); end
      end
      gap();
    end
    ticks(SERVE_FRAMES);
    checks++; if (run_en !== 1'b1) begin errors++; $display("FAIL sim_replay got %b want 1", run_en); end
  endtask

  task automatic test_scoring();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      if ($urandom_range(0, 1) == 0) step();
      hit_paddle = 1'b1;
      step();
      hit_paddle = 1'b0;
      m_score = (m_score + 1 > ScoreMax) ? ScoreMax : m_score + 1;
      if (i == 100) begin
        checks++; if (score !== SCORE_W'(m_score)) begin errors++; $display("FAIL score_mid got %0d want %0d", score, m_score); end
      end
    end
    checks++; if (score !== SCORE_W'(m_score)) begin errors++; $display("FAIL score_sat got %0d want %0d", score, m_score); end
    checks++; if (tone_sel !== 2'd1) begin errors++; $display("FAIL paddle_tone got %0d want 1", tone_sel); end
    ticks(3);
    checks++; if (tone_sel !== 2'd1 || tone_en !== 1'b1) begin
      errors++; $display("FAIL paddle_tone_hold got sel=%0d en=%b want 1 1", tone_sel, tone_en);
    end
    ticks(1);
    checks++; if (tone_sel !== 2'd0 || tone_en !== 1'b0) begin
      errors++; $display("FAIL paddle_tone_end got sel=%0d en=%b want 0 0", tone_sel, tone_en);
    end
  endtask

  // Tone model: rank table and durations indexed by tone code.
  task automatic test_tone_random();
    int rank[4] = '{0, 2, 1, 3};
    int dur[4]  = '{0, 4, 2, 16};
    int m_sel = 0, m_dur = 0, ev;
    logic hp, hw, ft;
    for (int c = 0; c < 200; c++) begin
      hp = ($urandom_range(0, 7) == 0);
      hw = ($urandom_range(0, 5) == 0);
      ft = ($urandom_range(0, 2) == 0);
      hit_paddle = hp;
      hit_wall = hw;
      frame_tick = ft;
      step();
      hit_paddle = 1'b0;
      hit_wall = 1'b0;
      frame_tick = 1'b0;
      ev = hp ? 1 : (hw ? 2 : 0);
      if (ev != 0 && rank[ev] >= rank[m_sel]) begin
        m_sel = ev;
        m_dur = dur[ev];
      end else if (ft && m_dur > 0) begin
        m_dur--;
        if (m_dur == 0) m_sel = 0;
      end
      checks++; if (tone_sel !== 2'(m_sel) || tone_en !== (m_sel != 0)) begin
        errors++; $display("FAIL tone_model cyc=%0d got sel=%0d en=%b want %0d %b", c, tone_sel, tone_en, m_sel, m_sel != 0);
      end
    end
    checks++; if (score !== SCORE_W'(m_score)) begin errors++; $display("FAIL tone_score got %0d want %0d", score, m_score); end
  endtask

  task automatic test_pause_serve();
    ball_missed = 1'b1;
    step();
    ball_missed = 1'b0;
    m_lives--;
    checks++; if (lives !== 3'(m_lives)) begin errors++; $display("FAIL ps_lives got %0d want %0d", lives, m_lives); end
    ticks(MISS_FRAMES);
    ticks(SERVE_FRAMES - 20);
    press_pause();
    checks++; if (paused !== 1'b1 || tone_en !== 1'b0) begin
      errors++; $display("FAIL ps_enter got paused=%b tone=%b want 1 0", paused, tone_en);
    end
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++; if (paused !== 1'b1 || run_en !== 1'b0) begin
        errors++; $display("FAIL ps_hold tick=%0d got paused=%b run=%b want 1 0", i, paused, run_en);
      end
      gap();
    end
    press_pause();
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL ps_exit got %b want 0", paused); end
    ticks(19);
    checks++; if (run_en !== 1'b0) begin errors++; $display("FAIL ps_run_early got %b want 0", run_en); end
    ticks(1);
    checks++; if (run_en !== 1'b1) begin errors++; $display("FAIL ps_run got %b want 1", run_en); end
  endtask

  task automatic test_game_over();
    ball_missed = 1'b1;
    step();
    ball_missed = 1'b0;
    m_lives--;
    checks++; if (lives !== 3'(m_lives)) begin errors++; $display("FAIL go_lives got %0d want %0d", lives, m_lives); end
    ticks(MISS_FRAMES - 1);
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL go_early got %b want 0", game_over); end
    tick();
    checks++; if (game_over !== 1'b1 || run_en !== 1'b0 || tone_sel !== 2'd0) begin
      errors++; $display("FAIL go_enter got over=%b run=%b tone=%0d want 1 0 0", game_over, run_en, tone_sel);
    end
    press_pause();
    checks++; if (paused !== 1'b0 || game_over !== 1'b1) begin
      errors++; $display("FAIL go_pause_ignored got paused=%b over=%b want 0 1", paused, game_over);
    end
    press_new_game();
    m_lives = LIVES;
    m_score = 0;
    checks++; if (lives !== 3'(m_lives) || score !== '0 || game_over !== 1'b0) begin
      errors++; $display("FAIL go_restart got lives=%0d score=%0d over=%b want %0d 0 0", lives, score, game_over, m_lives);
    end
  endtask

  task automatic test_reset_mid();
    ticks(SERVE_FRAMES);
    hit_paddle = 1'b1;
    step();
    reset = 1'b1;
    frame_tick = 1'b1;
    step();
    reset = 1'b0;
    hit_paddle = 1'b0;
    frame_tick = 1'b0;
    checks++; if (game_over !== 1'b1 || score !== '0 || lives !== 3'd0 || run_en !== 1'b0) begin
      errors++; $display("FAIL reset_mid got over=%b score=%0d lives=%0d run=%b want 1 0 0 0", game_over, score, lives, run_en);
    end
  endtask

`ifdef SQUASH_DEBOUNCE_EN
  task automatic test_debounce();
    new_game_n = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 8 && game_over !== 1'b0; i++) begin
      tick();
      repeat (3) step();
    end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL db_new_game got %b want 0", game_over); end
    new_game_n = 1'b1;
    repeat (3) step();
    ticks(4);
    pause_n = 1'b0;
    repeat (3) step();
    repeat (2) begin tick(); step(); end
    pause_n = 1'b1;
    repeat (3) step();
    ticks(2);
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL db_glitch got %b want 0", paused); end
    pause_n = 1'b0;
    repeat (3) step();
    repeat (4) begin tick(); step(); end
    repeat (3) step();
    checks++; if (paused !== 1'b1) begin errors++; $display("FAIL db_press got %b want 1", paused); end
    pause_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
`ifdef SQUASH_DEBOUNCE_EN
    test_debounce();
`else
    test_new_game();
    test_simultaneous();
    test_scoring();
    test_tone_random();
    test_pause_serve();
    test_game_over();
    test_reset_mid();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
